// File: rtl/alu_pkg.sv
// Shared definitions for the shift sequencer: shift mode and FSM state encodings
// plus the default datapath widths.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 3;

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step. Purely combinational; the sequencer applies it
// once per SHIFT cycle.
module shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] value_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] value_o,
  output logic             carry_out_o
);

  always_comb begin
    value_o     = value_i;
    carry_out_o = 1'b0;
    case (mode_i)
      MODE_LSL: begin
        value_o     = {value_i[WIDTH-2:0], 1'b0};
        carry_out_o = value_i[WIDTH-1];
      end
      MODE_LSR: begin
        value_o     = {1'b0, value_i[WIDTH-1:1]};
        carry_out_o = value_i[0];
      end
      MODE_ASR: begin
        value_o     = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
        carry_out_o = value_i[0];
      end
      MODE_ROR: begin
        value_o     = {value_i[0], value_i[WIDTH-1:1]};
        carry_out_o = value_i[0];
      end
      default: begin
        value_o     = value_i;
        carry_out_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle shifter: accepts one request, applies one 1-bit step per cycle,
// then holds the result until the consumer takes it.
module alu_shift_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] operand,
  input  logic [CNT_W-1:0] amount,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid never depends on ready, and the payload is held while
  // valid is high and ready is low.

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] step_value;
  logic             step_carry;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value_i     (result_q),
    .mode_i      (mode_q),
    .value_o     (step_value),
    .carry_out_o (step_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      mode_q   <= MODE_LSL;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          result_d = operand;
          carry_d  = 1'b0;
          cnt_d    = amount;
          mode_d   = mode_e'(mode);
          state_d  = (amount == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        result_d = step_value;
        carry_d  = step_carry;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        // Returning through IDLE guarantees a gap cycle before the next accept.
        if (done_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_ready = (state_q == ST_IDLE);
    done_valid  = (state_q == ST_DONE);
    busy        = (state_q != ST_IDLE);
    result      = result_q;
    carry       = carry_q;
    zero        = (result_q == '0);
  end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Bench for alu_shift_sequencer: directed corner cases plus randomized traffic
// with random consumer backpressure, checked against an arithmetic shift model.
module tb_alu_shift_sequencer;

  localparam int W  = 8;
  localparam int EW = 18; // {latency[7:0], zero, carry, result[7:0]}

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] operand = '0;
  logic [2:0]   amount = '0;
  logic [1:0]   mode = '0;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         done_valid;
  logic         done_ready = 1'b0;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit force_low = 1'b0;
  bit in_done = 1'b0;
  logic [9:0] held;

  logic [EW-1:0] exp_q[$];
  int            acc_q[$];

  alu_shift_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .operand     (operand),
    .amount      (amount),
    .mode        (mode),
    .result      (result),
    .carry       (carry),
    .zero        (zero),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: whole-amount shift with plain operators.
  function automatic logic [EW-1:0] model(input logic [W-1:0] op, input int amt,
                                          input logic [1:0] md);
    logic [W-1:0] r;
    logic         c;
    r = op;
    c = 1'b0;
    if (amt != 0) begin
      case (md)
        2'd0: begin r = op << amt; c = op[W-amt]; end
        2'd1: begin r = op >> amt; c = op[amt-1]; end
        2'd2: begin r = W'($signed(op) >>> amt); c = op[amt-1]; end
        default: begin r = (op >> amt) | (op << (W-amt)); c = r[W-1]; end
      endcase
    end
    return {8'(amt + 1), (r == '0), c, r};
  endfunction

  // driver
  task automatic issue(input logic [W-1:0] op, input int amt, input logic [1:0] md,
                       input bit push);
    int guard;
    @(negedge clk);
    operand = op;
    amount = 3'(amt);
    mode = md;
    start_valid = 1'b1;
    guard = 0;
    while (!start_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!start_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
      start_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (push) begin
      exp_q.push_back(model(op, amt, md));
      acc_q.push_back(cyc);
    end
    start_valid = 1'b0;
    operand = W'($urandom);
    amount = 3'($urandom);
    mode = 2'($urandom);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (guard < 300 && (exp_q.size() != 0 || done_valid || busy)) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=pending%0d required=pending0", exp_q.size());
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int lat;
    logic nd;
    if (rst_n) begin
      if (done_valid) begin
        if (!in_done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=done_valid required=idle");
          end else begin
            e = exp_q.pop_front();
            lat = cyc - acc_q.pop_front() + 1;
            chk("result", 32'(result), 32'(e[7:0]));
            chk("carry", 32'(carry), 32'(e[8]));
            chk("zero", 32'(zero), 32'(e[9]));
            chk("latency", 32'(lat), 32'(e[17:10]));
          end
          held = {zero, carry, result};
          in_done = 1'b1;
        end else begin
          chk("hold_stable", 32'({zero, carry, result}), 32'(held));
        end
      end
      nd = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      done_ready = nd;
      if (done_valid && nd) in_done = 1'b0;
    end
  end

  initial begin
    int guard;
    bit saw_done;

    // reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_done_valid", 32'(done_valid), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_start_ready", 32'(start_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_carry", 32'(carry), 32'h0);
    chk("rst_zero", 32'(zero), 32'h1);

    // directed corners
    issue(8'h87, 2, 2'd2, 1'b1);
    issue(8'h01, 1, 2'd3, 1'b1);
    issue(8'h01, 1, 2'd1, 1'b1);
    for (int m = 0; m < 4; m++) issue(8'h5A, 0, 2'(m), 1'b1);
    issue(8'h80, 7, 2'd2, 1'b1);
    issue(8'h81, 7, 2'd0, 1'b1);
    wait_idle();

    // long hold in DONE with start_valid noise
    force_low = 1'b1;
    issue(8'h3C, 4, 2'd0, 1'b1);
    guard = 0;
    while (!done_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("hold_reached_done", 32'(done_valid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_valid = 1'b1;
      operand = W'($urandom);
      amount = 3'd1;
      chk("hold_start_ready", 32'(start_ready), 32'h0);
      chk("hold_busy", 32'(busy), 32'h1);
      chk("hold_done_valid", 32'(done_valid), 32'h1);
    end
    @(negedge clk);
    start_valid = 1'b0;
    force_low = 1'b0;
    wait_idle();

    // reset mid-SHIFT
    issue(8'hFF, 7, 2'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_busy_before_rst", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_result", 32'(result), 32'h0);
    chk("mid_rst_carry", 32'(carry), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done_valid", 32'(done_valid), 32'h0);
    exp_q.delete();
    acc_q.delete();
    in_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_valid) saw_done = 1'b1;
    end
    chk("no_done_after_rst", 32'(saw_done), 32'h0);
    chk("ready_after_rst", 32'(start_ready), 32'h1);
    issue(8'h0F, 3, 2'd1, 1'b1);
    wait_idle();

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      issue(W'($urandom), $urandom_range(0, 7), 2'($urandom_range(0, 3)), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_shift_sequencer.md
ALU_SHIFT_SEQUENCER -- requirements
Module: alu_shift_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-002 SHALL have parameter CNT_W, default 3, shift-amount width; a shift amount SHALL be 0..WIDTH-1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_valid  input  1  request present.
REQ-006 SHALL have port start_ready  output  1  block can accept a request.
REQ-007 SHALL have port operand  input  WIDTH  value to shift.
REQ-008 SHALL have port amount  input  CNT_W  number of bit positions.
REQ-009 SHALL have port mode  input  2  00 LSL, 01 LSR, 10 ASR (sign-fill), 11 ROR.
REQ-010 SHALL have port result  output  WIDTH  shifted value.
REQ-011 SHALL have port carry  output  1  last bit shifted or rotated out.
REQ-012 SHALL have port zero  output  1  high when result equals 0.
REQ-013 SHALL have port done_valid  output  1  result/carry/zero valid.
REQ-014 SHALL have port done_ready  input  1  consumer accepts result.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-017 start_ready SHALL be high only in IDLE; request accepted on the clk edge where start_valid and start_ready are both high.
REQ-018 On accept, SHALL register operand into result, amount into an internal counter, mode into a mode register, and clear carry.
REQ-019 On accept with amount = 0, SHALL go to DONE; result = operand, carry = 0; done_valid high one cycle after accept.
REQ-020 On accept with amount >= 1, SHALL go to SHIFT; each SHIFT cycle SHALL apply exactly one 1-bit step per mode and decrement the counter.
REQ-021 1-bit steps: LSL {r[W-2:0],0}, carry r[W-1]; LSR {0,r[W-1:1]}, carry r[0]; ASR {r[W-1],r[W-1:1]}, carry r[0]; ROR {r[0],r[W-1:1]}, carry r[0].
REQ-022 SHIFT cycle with counter = 1 SHALL perform its step and transition to DONE; done_valid high amount+1 cycles after accept.
REQ-023 In DONE, done_valid SHALL stay high and result/carry/zero SHALL hold stable until done_ready is high; that edge returns to IDLE.
REQ-024 start_valid SHALL be ignored outside IDLE; operand/amount/mode changes after accept SHALL not affect the in-flight operation.
REQ-025 zero SHALL be combinational from the result register (result == 0) and is meaningful only while done_valid is high.
REQ-026 A new request SHALL not be accepted in the same cycle as the DONE handshake (minimum one IDLE cycle between operations).

Reset
REQ-027 rst_n low SHALL immediately force IDLE, result = 0, carry = 0, counter = 0, mode = 00, done_valid = 0, busy = 0, start_ready = 1 on release.
REQ-028 Reset asserted in SHIFT or DONE SHALL abandon the operation with no done_valid pulse.

Structure
REQ-029 Mode encodings (LSL/LSR/ASR/ROR) and the FSM state encoding SHALL live in shared package alu_pkg, along with default WIDTH.
REQ-030 The 1-bit step datapath SHALL be a combinational sub-module shift_step (inputs value, mode; outputs value, carry_out), instantiated once.

Verification
REQ-031 ASR, operand 0x87, amount 2 -> result 0xE1, carry 1, zero 0, done_valid 3 cycles after accept.
REQ-032 ROR, operand 0x01, amount 1 -> result 0x80, carry 1, done_valid 2 cycles after accept; LSR 0x01 by 1 -> result 0x00, carry 1, zero 1.
REQ-033 Any mode, operand 0x5A, amount 0 -> result 0x5A, carry 0, done_valid 1 cycle after accept.
REQ-034 done_ready held low 5 cycles in DONE -> done_valid and result stable throughout; start_valid pulses during this window not accepted.
REQ-035 rst_n pulsed low mid-SHIFT (LSL 0xFF by 7) -> outputs return to reset values immediately, no done_valid, next request completes correctly.
